pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Parametrised pipeline controller for the pipelined RV32 core; successor to the hard-wired stall logic, where `!stall` drives only the PC and IF/ID loads and ID/EX, EX/MEM and MEM/WB always load.
- Owns per-register load, bubble and valid bits for NUM_STAGES pipeline registers.
- Handles load-use hazards, taken-branch/jump flush, multi-cycle data-memory wait and an ecall drain/halt state machine.
- Keeps retire and stall counters.
- Sits beside the datapath; the datapath zeroes a register's control fields whenever its bubble bit is set.

Parameters:
- NUM_STAGES, 5, number of state-holding points. Index 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4..N-1 = later registers, N-1 = MEM/WB. Legal range 5..8.
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 32, width of the retire and stall counters.

Ports:
- clk, in, 1, system clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-low reset.
- id_rs1, in, REG_ADDR_W, rs1 of the instruction in IF/ID.
- id_rs2, in, REG_ADDR_W, rs2 of the instruction in IF/ID.
- id_uses_rs1, in, 1, IF/ID instruction reads rs1.
- id_uses_rs2, in, 1, IF/ID instruction reads rs2.
- ex_rd, in, REG_ADDR_W, rd of the instruction in ID/EX.
- ex_mem_read, in, 1, ID/EX instruction is a load.
- ex_branch_taken, in, 1, branch_CU/jal/jalr redirect resolved in EX.
- ex_ecall, in, 1, ID/EX instruction is ecall.
- mem_busy, in, 1, data memory not ready; the whole pipe freezes.
- resume, in, 1, leave HALT.
- pc_load, out, 1, PC register load enable.
- reg_load, out, NUM_STAGES-1, load enable for registers 1..N-1.
- reg_bubble, out, NUM_STAGES-1, register i captures a bubble (valid 0, controls zeroed) when loading.
- valid, out, NUM_STAGES-1, registered valid bit per register.
- halted, out, 1, state == HALT.
- retire_cnt, out, CNT_W, retired instruction count.
- stall_cnt, out, CNT_W, load-use bubble count.

Behaviour:
- Reset (rst=0, async): state=RUN; valid=0; halted=0; retire_cnt=0; stall_cnt=0. Combinational outputs follow from these values.
- ex_ok = valid[2].
- Load-use hazard: lu = ex_ok & ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)) & valid[1].
- Priority, highest first: mem_busy > ecall > branch > load-use > normal.
- mem_busy=1:
  - all reg_load=0, pc_load=0, reg_bubble=0.
  - valid, state and counters hold (retire does not count).
  - Inputs from the frozen EX stage are re-evaluated once mem_busy drops.
- RUN, normal:
  - pc_load=1 and all reg_load=1.
  - valid[i] <= valid[i-1] for i>=2; valid[1] <= 1.
- RUN, load-use (lu):
  - pc_load=0, reg_load[1]=0; IF/ID holds.
  - reg_load[2..]=1 with reg_bubble[2]=1, so valid[2] <= 0.
  - stall_cnt += 1.
  - Exactly one bubble per hazard.
- RUN, branch (ex_ok & ex_branch_taken, no ecall):
  - pc_load=1 (the datapath selects the target).
  - reg_bubble[1]=reg_bubble[2]=1, so the two younger instructions are squashed.
  - Older registers advance normally.
  - A simultaneous lu is ignored.
- RUN, ecall (ex_ok & ex_ecall):
  - pc_load=0; reg_bubble[1]=reg_bubble[2]=1; older registers advance.
  - The ecall itself is dropped; state -> DRAIN.
- DRAIN:
  - pc_load=0; registers 1..2 load bubbles; registers 3..N-1 advance.
  - When valid[3..N-1] are all 0 at a clock edge, state -> HALT on that edge.
  - Hazard, branch and ecall inputs are ignored.
- HALT:
  - halted=1; pc_load=0; all reg_load=0.
  - resume=1 -> RUN on the next edge; the first fetch happens in the cycle after that edge.
  - resume outside HALT is ignored.
- Retire: retire_cnt += 1 on every edge where valid[N-1]=1 and mem_busy=0. Counters wrap modulo 2^CNT_W.
- Reset asserted mid-DRAIN or mid-stall returns immediately to RUN with an empty pipe.
- All outputs except valid, halted and the counters are combinational from state, valid and inputs.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding RUN=2'd0, DRAIN=2'd1, HALT=2'd2.
  - stage index constants IDX_PC=0, IDX_IFID=1, IDX_IDEX=2, IDX_EXMEM=3.
  - the reset value of valid (all zeros).
- One sub-module, pipe_hazard_cmp: the combinational load-use comparator producing lu. It replaces the current hazard_detection_unit, which has no uses_rs qualifiers and no rd!=0 check.

Test Plan:
- Reset, then release with 8 normal cycles (N=5) -> valid fills 0001, 0011, 0111, 1111. retire_cnt=4 after cycle 8; pc_load=1 throughout.
- lw x5 in ID/EX, add x6,x5,x1 in IF/ID (uses_rs1, rs1=5) -> one cycle with pc_load=0, reg_load[1]=0, reg_bubble[2]=1. stall_cnt=1. Same stimulus with ex_rd=0 -> no stall.
- ex_branch_taken=1 with lu simultaneously true -> reg_bubble[1:2]=11, pc_load=1, stall_cnt unchanged. valid[1]=valid[2]=0 next cycle.
- mem_busy held 3 cycles mid-stream -> all loads 0 and valid/retire_cnt frozen for exactly 3 cycles, then resume identical to the unstalled sequence.
- ex_ecall with EX/MEM and MEM/WB valid -> DRAIN for 2 cycles, then halted=1 with all valid=0. retire_cnt increases by 2. resume pulse -> halted=0 and pc_load=1 the next cycle.
- rst dropped during DRAIN -> valid=0, halted=0, counters=0 asynchronously.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: FSM encoding, stage indices
// and the reset value of the per-register valid bits.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam int IDX_PC    = 0;
    localparam int IDX_IFID  = 1;
    localparam int IDX_IDEX  = 2;
    localparam int IDX_EXMEM = 3;

    localparam logic VALID_RST = 1'b0;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Load-use comparator: flags an IF/ID instruction that reads the destination
// of a load still sitting in ID/EX. x0 never creates a dependency.
module pipe_hazard_cmp #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  id_ok,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_ok,
    output logic                  lu
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    assign lu      = ex_ok && id_ok && ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-register load/bubble/valid, hazard and flush
// handling, ecall drain/halt sequencing, retire and stall counters.
//
// state | meaning
// RUN   | normal issue; load-use stall, branch flush and ecall detection active
// DRAIN | ecall seen; fetch stopped, older instructions retire, younger squashed
// HALT  | pipe empty and frozen until resume
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_W-1:0]   id_rs1,
    input  logic [REG_ADDR_W-1:0]   id_rs2,
    input  logic                    id_uses_rs1,
    input  logic                    id_uses_rs2,
    input  logic [REG_ADDR_W-1:0]   ex_rd,
    input  logic                    ex_mem_read,
    input  logic                    ex_branch_taken,
    input  logic                    ex_ecall,
    input  logic                    mem_busy,
    input  logic                    resume,
    output logic                    pc_load,
    output logic [NUM_STAGES-1:1]   reg_load,
    output logic [NUM_STAGES-1:1]   reg_bubble,
    output logic [NUM_STAGES-1:1]   valid,
    output logic                    halted,
    output logic [CNT_W-1:0]        retire_cnt,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_nxt;
    logic [NUM_STAGES-1:1]   valid_nxt;
    logic [NUM_STAGES-1:1]   valid_src;
    logic                    ex_ok;
    logic                    lu;
    logic                    stall_inc;
    logic                    retire_inc;

    assign ex_ok = valid[IDX_IDEX];

    pipe_hazard_cmp #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_ok       (valid[IDX_IFID]),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_ok       (ex_ok),
        .lu          (lu)
    );

    // IF/ID is fed by the fetch, which always produces a live instruction.
    assign valid_src = {valid[NUM_STAGES-2:1], 1'b1};

    always_comb begin
        state_nxt  = state;
        pc_load    = 1'b0;
        reg_load   = '0;
        reg_bubble = '0;
        stall_inc  = 1'b0;
        if (!mem_busy) begin
            case (state)
                RUN: begin
                    reg_load = '1;
                    if (ex_ok && ex_ecall) begin
                        // the ecall is dropped along with the two younger slots
                        reg_bubble[IDX_IFID]  = 1'b1;
                        reg_bubble[IDX_IDEX]  = 1'b1;
                        reg_bubble[IDX_EXMEM] = 1'b1;
                        state_nxt             = DRAIN;
                    end else if (ex_ok && ex_branch_taken) begin
                        pc_load              = 1'b1;
                        reg_bubble[IDX_IFID] = 1'b1;
                        reg_bubble[IDX_IDEX] = 1'b1;
                    end else if (lu) begin
                        reg_load[IDX_IFID]   = 1'b0;
                        reg_bubble[IDX_IDEX] = 1'b1;
                        stall_inc            = 1'b1;
                    end else begin
                        pc_load = 1'b1;
                    end
                end
                DRAIN: begin
                    reg_load             = '1;
                    reg_bubble[IDX_IFID] = 1'b1;
                    reg_bubble[IDX_IDEX] = 1'b1;
                    if (~|valid[NUM_STAGES-1:IDX_EXMEM]) begin
                        state_nxt = HALT;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        valid_nxt = valid;
        for (int i = 1; i < NUM_STAGES; i++) begin
            if (reg_load[i]) begin
                valid_nxt[i] = valid_src[i] & ~reg_bubble[i];
            end
        end
    end

    assign retire_inc = valid[NUM_STAGES-1] && !mem_busy;
    assign halted     = (state == HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            valid      <= {(NUM_STAGES-1){VALID_RST}};
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            state <= state_nxt;
            valid <= valid_nxt;
            if (retire_inc) begin
                retire_cnt <= retire_cnt + CNT_ONE;
            end
            if (stall_inc) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

endmodule
